// File: rtl/jtag_tdo_capture.sv
// Receive side of the JTAG byte player: samples tdo on tck rising edges,
// packs bits LSB-first into bytes and buffers them in a readback FIFO.
module jtag_tdo_capture #(
   parameter int DEPTH    = 512,
   parameter int CNT_W    = 10,
   parameter int BITCNT_W = 32
) (
   input  logic                clk_in,
   input  logic                rst_fifo,
   input  logic                tck,
   input  logic                tdo,
   input  logic                capture_en,
   input  logic                flush,
   input  logic                read_enable_fifo,
   output logic [7:0]          data_out,
   output logic                data_valid,
   output logic                full_fifo,
   output logic                empty_fifo,
   output logic [CNT_W-1:0]    rd_data_count,
   output logic [BITCNT_W-1:0] bit_count,
   output logic                error_out
);

   localparam int AW = $clog2(DEPTH);

   logic                tckQ;
   logic [7:0]          shQ, shD, shSampled;
   logic [2:0]          bitIdxQ, bitIdxD;
   logic [BITCNT_W-1:0] bitCountQ;
   logic [AW-1:0]       wrPtrQ, rdPtrQ;
   logic [CNT_W-1:0]    countQ, countD;
   logic                fullQ, emptyQ, errorQ;
   logic [7:0]          dataOutQ;
   logic                dataValidQ;
   logic [7:0]          mem [DEPTH];

   logic sample, push, doRead, doWrite, overflow;

   // tck is generated in this clock domain, so a single delay register
   // is enough to find its rising edge.
   always_comb begin
      sample    = capture_en & tck & ~tckQ;
      shSampled = shQ;
      if (sample) begin
         shSampled[bitIdxQ] = tdo;
      end
      push     = (sample && bitIdxQ == 3'd7) || (flush && (sample || bitIdxQ != 3'd0));
      doRead   = read_enable_fifo & ~emptyQ;
      doWrite  = push & (~fullQ | doRead);
      overflow = push & fullQ & ~doRead;

      shD     = shQ;
      bitIdxD = bitIdxQ;
      if (push) begin
         shD     = 8'd0;
         bitIdxD = 3'd0;
      end else if (sample) begin
         shD     = shSampled;
         bitIdxD = bitIdxQ + 3'd1;
      end

      countD = countQ;
      if (doWrite && !doRead) begin
         countD = countQ + CNT_W'(1);
      end else if (doRead && !doWrite) begin
         countD = countQ - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_fifo) begin
         tckQ       <= 1'b0;
         shQ        <= 8'd0;
         bitIdxQ    <= 3'd0;
         bitCountQ  <= '0;
         wrPtrQ     <= '0;
         rdPtrQ     <= '0;
         countQ     <= '0;
         fullQ      <= 1'b0;
         emptyQ     <= 1'b1;
         errorQ     <= 1'b0;
         dataOutQ   <= 8'd0;
         dataValidQ <= 1'b0;
      end else begin
         tckQ    <= tck;
         shQ     <= shD;
         bitIdxQ <= bitIdxD;
         if (sample) begin
            bitCountQ <= bitCountQ + BITCNT_W'(1);
         end
         if (doWrite) begin
            wrPtrQ <= wrPtrQ + AW'(1);
         end
         if (doRead) begin
            rdPtrQ   <= rdPtrQ + AW'(1);
            dataOutQ <= mem[rdPtrQ];
         end
         dataValidQ <= doRead;
         countQ     <= countD;
         fullQ      <= (countD == CNT_W'(DEPTH));
         emptyQ     <= (countD == '0);
         if (overflow) begin
            errorQ <= 1'b1;
         end
      end
   end

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk_in) begin
      if (doWrite) begin
         mem[wrPtrQ] <= shSampled;
      end
   end

   assign data_out      = dataOutQ;
   assign data_valid    = dataValidQ;
   assign full_fifo     = fullQ;
   assign empty_fifo    = emptyQ;
   assign rd_data_count = countQ;
   assign bit_count     = bitCountQ;
   assign error_out     = errorQ;

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Bench for jtag_tdo_capture: directed tck/tdo sequences, with read data
// checked by a scoreboard monitor and status outputs checked directly.
module tb_jtag_tdo_capture;

   localparam int DEPTH    = 4;
   localparam int CNT_W    = 10;
   localparam int BITCNT_W = 32;

   logic                clk_in = 1'b0;
   logic                rst_fifo = 1'b1;
   logic                tck = 1'b0;
   logic                tdo = 1'b0;
   logic                capture_en = 1'b0;
   logic                flush = 1'b0;
   logic                read_enable_fifo = 1'b0;
   logic [7:0]          data_out;
   logic                data_valid;
   logic                full_fifo;
   logic                empty_fifo;
   logic [CNT_W-1:0]    rd_data_count;
   logic [BITCNT_W-1:0] bit_count;
   logic                error_out;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] sbQ [$];

   jtag_tdo_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W), .BITCNT_W(BITCNT_W)) dut (
      .clk_in(clk_in), .rst_fifo(rst_fifo), .tck(tck), .tdo(tdo),
      .capture_en(capture_en), .flush(flush), .read_enable_fifo(read_enable_fifo),
      .data_out(data_out), .data_valid(data_valid), .full_fifo(full_fifo),
      .empty_fifo(empty_fifo), .rd_data_count(rd_data_count),
      .bit_count(bit_count), .error_out(error_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Read data is compared against the scoreboard whenever the DUT flags it valid.
   always @(negedge clk_in) begin
      if (data_valid === 1'b1) begin
         if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedValid: got data 0x%0h, expected no read data", data_out);
         end else begin
            checkOutput("readData", {24'd0, data_out}, {24'd0, sbQ.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic applyStimulus(input logic b, input logic f, input logic r, input logic [7:0] rExp);
      tdo = b;
      tck = 1'b1;
      flush = f;
      read_enable_fifo = r;
      if (r) sbQ.push_back(rExp);
      tick();
      flush = 1'b0;
      read_enable_fifo = 1'b0;
      tck = 1'b0;
      tick();
   endtask

   task automatic sendByte(input logic [7:0] val);
      for (int i = 0; i < 8; i++) applyStimulus(val[i], 1'b0, 1'b0, 8'h00);
   endtask

   task automatic readByte(input logic [7:0] exp);
      read_enable_fifo = 1'b1;
      sbQ.push_back(exp);
      tick();
      read_enable_fifo = 1'b0;
   endtask

   task automatic pulseFlush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
   endtask

   task automatic doReset();
      rst_fifo = 1'b1;
      tick();
      tick();
      rst_fifo = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] partial;
      logic [7:0] b5;

      doReset();
      checkOutput("rstDataOut", {24'd0, data_out}, 32'h0);
      checkOutput("rstValid", {31'd0, data_valid}, 32'd0);
      checkOutput("rstFull", {31'd0, full_fifo}, 32'd0);
      checkOutput("rstEmpty", {31'd0, empty_fifo}, 32'd1);
      checkOutput("rstCount", {22'd0, rd_data_count}, 32'd0);
      checkOutput("rstBits", bit_count, 32'd0);
      checkOutput("rstError", {31'd0, error_out}, 32'd0);

      // Plain byte capture: 1,0,1,1,0,0,1,0 LSB-first is 0x4D.
      capture_en = 1'b1;
      applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0); applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0); applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
      checkOutput("byteCount", {22'd0, rd_data_count}, 32'd1);
      checkOutput("byteBits", bit_count, 32'd8);
      checkOutput("byteNotEmpty", {31'd0, empty_fifo}, 32'd0);
      readByte(8'h4D);
      checkOutput("readValid", {31'd0, data_valid}, 32'd1);
      tick();
      checkOutput("validDrop", {31'd0, data_valid}, 32'd0);
      checkOutput("readEmpty", {31'd0, empty_fifo}, 32'd1);

      // Partial flush of three ones, then a redundant flush.
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
      pulseFlush();
      checkOutput("flushCount", {22'd0, rd_data_count}, 32'd1);
      checkOutput("flushBits", bit_count, 32'd11);
      pulseFlush();
      checkOutput("flush2Count", {22'd0, rd_data_count}, 32'd1);
      readByte(8'h07);

      // Flush on the 8th edge stores exactly one byte (0xAA).
      partial = 8'hAA;
      for (int i = 0; i < 7; i++) applyStimulus(partial[i], 0, 0, 0);
      applyStimulus(partial[7], 1, 0, 0);
      checkOutput("flush8Count", {22'd0, rd_data_count}, 32'd1);
      pulseFlush();
      checkOutput("flush8IdxZero", {22'd0, rd_data_count}, 32'd1);
      checkOutput("flush8Bits", bit_count, 32'd19);
      readByte(8'hAA);

      // capture_en low ignores pulses.
      capture_en = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
      pulseFlush();
      checkOutput("disBits", bit_count, 32'd19);
      checkOutput("disCount", {22'd0, rd_data_count}, 32'd0);

      // tck already high when capture_en rises gives no sample.
      tck = 1'b1;
      tick();
      capture_en = 1'b1;
      tick();
      tck = 1'b0;
      tick();
      checkOutput("highTckBits", bit_count, 32'd19);

      // Mid-byte pause keeps the partial byte: 1,0,0 | 1,1,1,1,0 gives 0x79.
      applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0); applyStimulus(0, 0, 0, 0);
      capture_en = 1'b0;
      applyStimulus(0, 0, 0, 0); applyStimulus(0, 0, 0, 0);
      capture_en = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("pauseBits", bit_count, 32'd27);
      readByte(8'h79);

      // Overflow: five bytes into a four-deep FIFO.
      sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
      checkOutput("ovfFull", {31'd0, full_fifo}, 32'd1);
      checkOutput("ovfNoErrYet", {31'd0, error_out}, 32'd0);
      sendByte(8'h55);
      checkOutput("ovfError", {31'd0, error_out}, 32'd1);
      checkOutput("ovfCount", {22'd0, rd_data_count}, 32'd4);
      readByte(8'h11); readByte(8'h22); readByte(8'h33); readByte(8'h44);
      tick();
      checkOutput("ovfDrained", {31'd0, empty_fifo}, 32'd1);
      checkOutput("ovfErrSticky", {31'd0, error_out}, 32'd1);

      // Read while empty is ignored and data_out holds.
      read_enable_fifo = 1'b1;
      tick();
      read_enable_fifo = 1'b0;
      checkOutput("emptyRdValid", {31'd0, data_valid}, 32'd0);
      checkOutput("emptyRdHold", {24'd0, data_out}, 32'h44);

      // Push and read together while full.
      doReset();
      checkOutput("rstClrError", {31'd0, error_out}, 32'd0);
      sendByte(8'hA1); sendByte(8'hA2); sendByte(8'hA3); sendByte(8'hA4);
      b5 = 8'hB5;
      for (int i = 0; i < 7; i++) applyStimulus(b5[i], 0, 0, 0);
      applyStimulus(b5[7], 0, 1, 8'hA1);
      checkOutput("simCount", {22'd0, rd_data_count}, 32'd4);
      checkOutput("simError", {31'd0, error_out}, 32'd0);
      checkOutput("simFull", {31'd0, full_fifo}, 32'd1);
      checkOutput("simBits", bit_count, 32'd40);
      readByte(8'hA2); readByte(8'hA3); readByte(8'hA4); readByte(8'hB5);
      tick();

      // Reset mid-byte discards the partial bits.
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
      doReset();
      checkOutput("midRstBits", bit_count, 32'd0);
      sendByte(8'hC3);
      checkOutput("midRstCount", {22'd0, rd_data_count}, 32'd1);
      checkOutput("midRstBits8", bit_count, 32'd8);
      readByte(8'hC3);

      tick(); tick(); tick();
      checkOutput("sbDrained", sbQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
